// File: rtl/id_issue.sv
// id_issue: decode-to-issue stage with operand select, forwarding, load-use hazard stall and a registered issue slot
// Ports: clk/rst (async active-low); in_* decoded instruction + handshake; rf_addr*/rf_data* same-cycle
// register file read; fwd_* per-stage forwarding (index 0 youngest); flush; out_* registered issue
// payload + handshake; stall_cnt saturating hazard-stall cycle count.
module id_issue #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int OP_W    = 8,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_rs_addr,
  input  logic [ADDR_W-1:0]         in_rt_addr,
  input  logic                      in_rs_read,
  input  logic                      in_rt_read,
  input  logic [DATA_W-1:0]         in_imm,
  input  logic [ADDR_W-1:0]         in_wd,
  input  logic                      in_wreg,
  input  logic [OP_W-1:0]           in_op,
  output logic [ADDR_W-1:0]         rf_addr1,
  output logic [ADDR_W-1:0]         rf_addr2,
  input  logic [DATA_W-1:0]         rf_data1,
  input  logic [DATA_W-1:0]         rf_data2,
  input  logic [NUM_FWD-1:0]        fwd_wreg,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_reg1,
  output logic [DATA_W-1:0]         out_reg2,
  output logic [ADDR_W-1:0]         out_wd,
  output logic                      out_wreg,
  output logic [OP_W-1:0]           out_op,
  output logic [CNT_W-1:0]          stall_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] fwd1, fwd2, op1, op2;
  logic pend1, pend2, hazard, accept;
  assign rf_addr1 = in_rs_addr;
  assign rf_addr2 = in_rt_addr;
  // Scan from the oldest source down so the youngest matching stage wins.
  always_comb begin
    fwd1 = rf_data1;
    fwd2 = rf_data2;
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_wreg[i] && fwd_wd[i*ADDR_W +: ADDR_W] == in_rs_addr) begin
        fwd1 = fwd_wdata[i*DATA_W +: DATA_W];
        pend1 = fwd_pending[i];
      end
      if (fwd_wreg[i] && fwd_wd[i*ADDR_W +: ADDR_W] == in_rt_addr) begin
        fwd2 = fwd_wdata[i*DATA_W +: DATA_W];
        pend2 = fwd_pending[i];
      end
    end
  end
  assign op1 = !in_rs_read ? in_imm : ~|in_rs_addr ? '0 : fwd1;
  assign op2 = !in_rt_read ? in_imm : ~|in_rt_addr ? '0 : fwd2;
  assign hazard = in_valid && ((in_rs_read && |in_rs_addr && pend1) || (in_rt_read && |in_rt_addr && pend2));
  assign out_valid = state == FULL;
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  always_comb begin
    state_nx = state;
    if (flush) state_nx = EMPTY;
    else if (accept) state_nx = FULL;
    else if (out_ready) state_nx = EMPTY;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      out_reg1 <= '0;
      out_reg2 <= '0;
      out_wd <= '0;
      out_wreg <= 1'b0;
      out_op <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        out_reg1 <= op1;
        out_reg2 <= op2;
        out_wd <= in_wd;
        out_wreg <= in_wreg;
        out_op <= in_op;
      end
      if (hazard && !flush && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule
